// File: rtl/keypad_pkg.sv
// Shared constants and types for the 4x4 hex keypad scanner.
// Snapshot bit index is row*COLS+col; KEY_MAP turns that index into the printed hex legend.
package keypad_pkg;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHeld   = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  typedef enum logic [1:0] {
    ClsNone,
    ClsSingle,
    ClsMulti
  } snap_class_e;

  // Entry 15 first: row3 = 0,F,E,D ... row0 = 1,2,3,A
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEY_MAP[idx];
  endfunction

endpackage

// File: rtl/keymap_encoder.sv
// Classifies a 16-bit keypad snapshot (none/single/multi) and encodes the lowest pressed key.
module keymap_encoder
  import keypad_pkg::*;
(
  input  logic [15:0]  snap_i,
  output snap_class_e  cls_o,
  output logic [3:0]   code_o
);

  logic [3:0] low_idx;
  logic       multi;

  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (snap_i[i]) low_idx = 4'(i);
    end
    // Clearing the lowest set bit leaves something only if two or more were set
    multi = |(snap_i & (snap_i - 16'd1));
    if (snap_i == 16'd0) begin
      cls_o = ClsNone;
    end else if (multi) begin
      cls_o = ClsMulti;
    end else begin
      cls_o = ClsSingle;
    end
    code_o = key_lookup(low_idx);
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-multiplexed 4x4 keypad scanner: drives one column low at a time, debounces whole
// snapshots and emits one key_valid pulse per accepted single-key press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [3:0]      row_s1_q, row_s2_q;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [15:0]     work_map_q, work_map_d;
  logic [15:0]     prev_snap_q, prev_snap_d;
  logic [3:0]      match_cnt_q, match_cnt_d;
  logic [1:0]      state_q, state_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;

  logic            sample, scan_done, stable;
  snap_class_e     snap_cls;
  logic [3:0]      snap_code;

  assign sample    = (div_cnt_q == DivW'(SCAN_DIV - 1));
  assign scan_done = sample && (col_idx_q == 2'd3);

  always_comb begin
    div_cnt_d  = sample ? '0 : div_cnt_q + 1'b1;
    col_idx_d  = sample ? col_idx_q + 2'd1 : col_idx_q;
    work_map_d = work_map_q;
    if (sample) begin
      for (int r = 0; r < ROWS; r++) begin
        work_map_d[{2'(r), col_idx_q}] = ~row_s2_q[r];
      end
    end
  end

  // On scan_done, work_map_d already holds the completed snapshot including column 3
  keymap_encoder u_encoder (
    .snap_i (work_map_d),
    .cls_o  (snap_cls),
    .code_o (snap_code)
  );

  always_comb begin
    match_cnt_d = match_cnt_q;
    prev_snap_d = prev_snap_q;
    if (scan_done) begin
      prev_snap_d = work_map_d;
      if (work_map_d == prev_snap_q) begin
        if (match_cnt_q != 4'(DEBOUNCE_SCANS)) match_cnt_d = match_cnt_q + 4'd1;
      end else begin
        match_cnt_d = 4'd1;
      end
    end
    stable = scan_done && (match_cnt_d == 4'(DEBOUNCE_SCANS));
  end

  always_comb begin
    state_d     = state_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (stable) begin
      case (state_q)
        StIdle: begin
          if (snap_cls == ClsSingle) begin
            key_code_d  = snap_code;
            key_valid_d = 1'b1;
            state_d     = StHeld;
          end else if (snap_cls == ClsMulti) begin
            state_d = StLocked;
          end
        end
        StHeld: begin
          // The key map is one-to-one, so same single code means same snapshot
          if (snap_cls == ClsNone) begin
            state_d = StIdle;
          end else if (!(snap_cls == ClsSingle && snap_code == key_code_q)) begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (snap_cls == ClsNone) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      row_s1_q    <= 4'b1111;
      row_s2_q    <= 4'b1111;
      div_cnt_q   <= '0;
      col_idx_q   <= 2'd0;
      work_map_q  <= 16'd0;
      prev_snap_q <= 16'd0;
      match_cnt_q <= 4'd0;
      state_q     <= StIdle;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      row_s1_q    <= ROW;
      row_s2_q    <= row_s1_q;
      div_cnt_q   <= div_cnt_d;
      col_idx_q   <= col_idx_d;
      work_map_q  <= work_map_d;
      prev_snap_q <= prev_snap_d;
      match_cnt_q <= match_cnt_d;
      state_q     <= state_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign COL       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == StHeld);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Column-multiplexed scanner for the 4x4 hex keypad used to set clock and alarm time. It drives one keypad column low at a time, the input-side counterpart of the anode-multiplexed seven-segment display. It samples the active-low rows, debounces whole-keypad snapshots and emits one pulse per accepted key press. Downstream time-set logic consumes key_code on key_valid.

Parameters:
SCAN_DIV, 100000, clock cycles each column stays active (1 ms at 100 MHz); legal range is 4 or more.
DEBOUNCE_SCANS, 4, number of consecutive identical full-scan snapshots required before a snapshot counts as stable; legal range is 2 to 15.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz.
reset  input  1  asynchronous, active-high reset.
ROW  input  4  keypad rows, active-low (pulled up externally), asynchronous to the clock.
COL  output  4  keypad column drive, active-low, exactly one bit low at any time.
key_code  output  4  hex value of the last accepted key.
key_valid  output  1  one-cycle pulse when key_code is newly accepted.
key_held  output  1  high while the accepted key remains stably pressed.

Behaviour:
- Reset (async, active-high) sets: COL=4'b1110, key_code=0, key_valid=0, key_held=0, FSM=IDLE, all counters 0, snapshot registers 0, synchronizer flops 4'b1111.
- Synchronizer: ROW passes through a 2-flop synchronizer before any use.
- Column sequencing:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - col_idx advances 0,1,2,3,0 on the wrap.
  - COL = ~(1 << col_idx).
- Sampling: on the cycle div_cnt==SCAN_DIV-1, the inverted synchronized rows are written into bits {row,col_idx} of the working map, at bit index row*4+col.
- Scan end: the sample with col_idx==3 completes a 16-bit snapshot (a scan_done strobe).
  - The snapshot is compared with the previous snapshot.
  - Equal: match_cnt increments, saturating at DEBOUNCE_SCANS.
  - Different: match_cnt=1.
  - Stable means match_cnt==DEBOUNCE_SCANS after the update.
- Snapshot classes:
  - NONE: zero bits set.
  - SINGLE: exactly one bit set.
  - MULTI: two or more bits set.
- Key map (row-major, col0 leftmost): row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D.
- FSM, evaluated only on scan_done while stable:
  - IDLE:
    - SINGLE: latch key_code from the map, key_valid=1 for exactly the next cycle, go to HELD.
    - MULTI: go to LOCKED.
    - NONE: stay.
  - HELD (key_held=1):
    - NONE: go to IDLE.
    - Same snapshot: stay, with no further pulses (no auto-repeat).
    - Any different nonzero snapshot (rollover or second key): go to LOCKED.
  - LOCKED:
    - Stable NONE: go to IDLE.
    - Anything else: stay. No pulses are produced in LOCKED.
- Latency: key_valid rises 1 cycle after the scan_done of the DEBOUNCE_SCANS-th consecutive identical SINGLE snapshot.
- key_code holds its value until the next accepted key. key_held is low in IDLE and LOCKED.
- Bounce: any snapshot change resets match_cnt, so the FSM does not act until the new snapshot has been stable.
- Reset mid-scan or mid-press: everything returns to reset values. A key still held after reset is re-accepted after DEBOUNCE_SCANS full scans and produces a fresh pulse.

Decomposition:
- keypad_pkg holds:
  - the state enum (IDLE, HELD, LOCKED);
  - the 16-entry key-map constant (index to hex code);
  - the ROWS/COLS=4 constants.
- One sub-module, keymap_encoder (combinational): takes the 16-bit snapshot and returns the class (NONE/SINGLE/MULTI) and the 4-bit code of the lowest set bit.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_SCANS=3. The bench keypad model pulls ROW[r] low while key (r,c) is pressed and COL[c] is low.
- Reset check: assert reset mid-scan -> COL=1110, key_valid=0, key_held=0, key_code=0 immediately, without waiting for a clock edge.
- Single press: press (row1,col2) ("6") for 10 scans, then release -> exactly one key_valid pulse with key_code=4'h6. The pulse comes 1 cycle after the 3rd identical scan_done. key_held stays high until 3 stable NONE scans after release.
- Bounce: toggle "A" (row0,col3) every scan for 4 scans, then hold steady -> no pulse during toggling; one pulse with code 4'hA after 3 steady scans.
- Two keys: press "1" and "D" together -> no key_valid; FSM reaches LOCKED. Release both and then press "0" -> one pulse with code 4'h0.
- Rollover: hold "5", then add "9" -> one pulse with 4'h5 only. Release "5" while keeping "9" -> no pulse. Release all and then press "9" -> a pulse with 4'h9.
- COL walk: with no keys pressed, COL cycles 1110, 1101, 1011, 0111, each lasting 4 cycles, with exactly one bit low in every cycle.
